// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - pipelined instruction fetch front end with in-order response FIFO
// Define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_INC   = XLEN'(1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [31:0]     id_instr_o,
  output logic [XLEN-1:0] id_pc_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {FETCH, FLUSH} state_e;
  state_e state_q, state_d;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] tag_mem   [DEPTH];

  logic            empty, req_fire, rsp_keep, bypass, push, pop;
  logic [CW:0]     credit_used;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    tag_rd_d      = tag_rd_q;
    tag_wr_d      = tag_wr_q;

    empty       = (count_q == '0);
    // Every in-flight request owns a FIFO slot, so responses never need back-pressure.
    credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
    imem_req_valid_o = rst_ni && (state_q == FETCH) && !redirect_i &&
                       (credit_used < (CW+1)'(DEPTH));
    imem_req_addr_o  = fetch_pc_q;
    req_fire         = imem_req_valid_o && imem_req_ready_i;
    rsp_keep         = imem_rsp_valid_i && (drop_cnt_q == '0) && !redirect_i;

`ifdef FETCH_BYPASS_EN
    bypass = rst_ni && empty && rsp_keep;
`else
    bypass = 1'b0;
`endif

    id_valid_o = (!empty && !redirect_i) || bypass;
    id_instr_o = empty ? '0 : instr_mem[rd_ptr_q];
    id_pc_o    = empty ? '0 : pc_mem[rd_ptr_q];
    if (bypass) begin
      id_instr_o = imem_rsp_data_i;
      id_pc_o    = tag_mem[tag_rd_q];
    end

    pop  = !empty && id_valid_o && id_ready_i;
    push = rsp_keep && !(bypass && id_ready_i);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_INC;
      tag_wr_d   = tag_wr_q + AW'(1);
    end
    // Tags retire on every response, dropped or kept, since responses stay in order.
    if (imem_rsp_valid_i) begin
      tag_rd_d = tag_rd_q + AW'(1);
      if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
    end
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      drop_cnt_d = outstanding_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      state_d    = (outstanding_d != '0) ? FLUSH : FETCH;
    end else if ((state_q == FLUSH) && (drop_cnt_d == '0)) begin
      state_d = FETCH;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rsp_data_i;
      pc_mem[wr_ptr_q]    <= tag_mem[tag_rd_q];
    end
    if (req_fire) tag_mem[tag_wr_q] <= fetch_pc_q;
  end

endmodule
